adder_tree_driver: RTL and testbench

- Producer-side controller for the pipelined signed adder tree.
- Accepts a serial valid/ready sample stream and assembles N samples into a parallel lane vector.
- Drives that vector and the tree's clock enable for exactly the tree depth, then captures the tree sum.
- Presents the sum on a valid/ready output handshake. Sits between a sample source (e.g. FIR tap products) and the tree instance.

---
 rtl/adder_tree_driver.sv | 83 ++++++++
 tb/tb_adder_tree_driver.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/adder_tree_driver.sv
// adder_tree_driver: gathers serial samples into a lane vector, flushes the adder tree, holds its sum.
// Optional ADDER_TREE_DRV_SHORT_FRAME_EN: an accepted in_last ends the frame early with zero-padded lanes.
module adder_tree_driver #(
    parameter int N = 32,
    parameter int DATA_WIDTH = 33,
    parameter int RESULT_WIDTH = DATA_WIDTH + $clog2(N) + ((N - 1 >= 2 ** $clog2(N)) ? 1 : 0),
    parameter int TREE_DELAY = $clog2(N)
) (
    input  logic                               clock,
    input  logic                               reset,
    input  logic                               in_valid,
    output logic                               in_ready,
    input  logic [DATA_WIDTH-1:0]              in_data,
    input  logic                               in_last,
    output logic [N-1:0][DATA_WIDTH-1:0]       tree_data,
    output logic                               tree_ena,
    input  logic [RESULT_WIDTH-1:0]            tree_result,
    output logic                               out_valid,
    input  logic                               out_ready,
    output logic [RESULT_WIDTH-1:0]            out_sum
);
    localparam int CW = $clog2(N);
    localparam int FW = $clog2(TREE_DELAY + 1);

    typedef enum logic [1:0] {FILL, FLUSH, CAPTURE, HOLD} state_t;

    state_t state, state_next;
    logic [CW-1:0] count;
    logic [FW-1:0] flush_count;
    logic accept, frame_end;

`ifdef ADDER_TREE_DRV_SHORT_FRAME_EN
    assign frame_end = accept && (count == CW'(N - 1) || in_last);
`else
    logic unused_last;
    assign unused_last = in_last;
    assign frame_end = accept && count == CW'(N - 1);
`endif

    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= FILL;
        else state <= state_next;
    end

    always_comb begin
        state_next = state;
        in_ready = state == FILL;
        tree_ena = state == FLUSH;
        accept = in_valid && in_ready;
        case (state)
            FILL:    state_next = frame_end ? FLUSH : FILL;
            FLUSH:   state_next = flush_count == FW'(TREE_DELAY - 1) ? CAPTURE : FLUSH;
            CAPTURE: state_next = HOLD;
            HOLD:    state_next = out_ready ? FILL : HOLD;
            default: state_next = FILL;
        endcase
    end

    // Lanes not written in a short frame keep the zeros left by the previous clear.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count <= '0;
            flush_count <= '0;
            tree_data <= '0;
            out_valid <= 1'b0;
            out_sum <= '0;
        end else begin
            if (accept) begin
                tree_data[count] <= in_data;
                count <= frame_end ? '0 : count + 1'b1;
            end
            flush_count <= tree_ena ? flush_count + 1'b1 : '0;
            if (state == CAPTURE) begin
                out_sum <= tree_result;
                out_valid <= 1'b1;
            end
            if (state == HOLD && out_ready) begin
                out_valid <= 1'b0;
                tree_data <= '0;
            end
        end
    end
endmodule

// File: tb/tb_adder_tree_driver.sv
// tb_adder_tree_driver: directed checks of the tree driver with a behavioural two-stage adder tree.
module tb_adder_tree_driver;
    logic clk = 0, rst = 1;
    always #5 clk = ~clk;

    int total = 0, bad = 0;

    logic v4 = 0, l4 = 0, or4 = 1, r4, te4, ov4;
    logic [7:0] d4 = 0;
    logic [3:0][7:0] td4;
    logic [9:0] tr4, os4;
    logic signed [9:0] s4a, s4b;

    logic v3 = 0, or3 = 1, r3, te3, ov3;
    logic [7:0] d3 = 0;
    logic [2:0][7:0] td3;
    logic [9:0] tr3, os3;
    logic signed [9:0] s3a, s3b;

    adder_tree_driver #(.N(4), .DATA_WIDTH(8)) u4 (
        .clock(clk), .reset(rst), .in_valid(v4), .in_ready(r4), .in_data(d4), .in_last(l4),
        .tree_data(td4), .tree_ena(te4), .tree_result(tr4), .out_valid(ov4), .out_ready(or4), .out_sum(os4));

    adder_tree_driver #(.N(3), .DATA_WIDTH(8)) u3 (
        .clock(clk), .reset(rst), .in_valid(v3), .in_ready(r3), .in_data(d3), .in_last(1'b0),
        .tree_data(td3), .tree_ena(te3), .tree_result(tr3), .out_valid(ov3), .out_ready(or3), .out_sum(os3));

    always @(posedge clk) if (te4) begin
        s4a <= $signed(td4[0]) + $signed(td4[1]) + $signed(td4[2]) + $signed(td4[3]);
        s4b <= s4a;
    end
    assign tr4 = s4b;

    always @(posedge clk) if (te3) begin
        s3a <= $signed(td3[0]) + $signed(td3[1]) + $signed(td3[2]);
        s3b <= s3a;
    end
    assign tr3 = s3b;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push4(input logic [7:0] v, input logic l);
        int n = 0;
        v4 = 1; d4 = v; l4 = l;
        while (!r4 && n < 50) begin @(negedge clk); n++; end
        if (n >= 50) chk("push4_timeout", 1, 0);
        @(negedge clk);
        v4 = 0; l4 = 0; d4 = 8'hA5;
    endtask

    task automatic push3(input logic [7:0] v);
        int n = 0;
        v3 = 1; d3 = v;
        while (!r3 && n < 50) begin @(negedge clk); n++; end
        if (n >= 50) chk("push3_timeout", 1, 0);
        @(negedge clk);
        v3 = 0; d3 = 8'h55;
    endtask

    task automatic wait_out4(input string tag, input logic [9:0] esum);
        int c = 0, en = 0;
        while (!ov4 && c < 20) begin en += int'(te4); c++; @(negedge clk); end
        chk({tag, "_lat"}, c, 3);
        chk({tag, "_ena"}, en, 2);
        chk({tag, "_sum"}, os4, esum);
    endtask

    initial begin
        #1;
        chk("rst_in_ready", r4, 1);
        chk("rst_tree_ena", te4, 0);
        chk("rst_out_valid", ov4, 0);
        chk("rst_out_sum", os4, 0);
        chk("rst_lanes", td4, 0);
        @(negedge clk); @(negedge clk);
        rst = 0;
        @(negedge clk);

        push4(1, 0); push4(2, 0); push4(3, 0); push4(4, 0);
        chk("t1_lanes", td4, 32'h04030201);
        wait_out4("t1", 10);
        @(negedge clk);
        chk("t1_out_valid_drop", ov4, 0);
        chk("t1_in_ready_back", r4, 1);

        or4 = 0;
        push4(8'h80, 0); push4(8'h80, 0); push4(8'h80, 0); push4(8'h80, 0);
        wait_out4("t2", 10'h200);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("bp_hold", {ov4, r4, te4, os4}, {1'b1, 1'b0, 1'b0, 10'h200});
        end
        or4 = 1;
        @(negedge clk);
        chk("bp_handshake_once", ov4, 0);
        chk("bp_in_ready_next", r4, 1);

        push4(5, 0); push4(6, 0); push4(7, 0); push4(8, 0);
        chk("rst_mid_in_flush", te4, 1);
        rst = 1;
        #1;
        chk("rst_mid_in_ready", r4, 1);
        chk("rst_mid_tree_ena", te4, 0);
        chk("rst_mid_out_valid", ov4, 0);
        chk("rst_mid_out_sum", os4, 0);
        chk("rst_mid_lanes", td4, 0);
        @(negedge clk);
        rst = 0;
        @(negedge clk);
        push4(1, 0); push4(1, 0); push4(1, 0); push4(1, 0);
        wait_out4("t4", 4);
        @(negedge clk);

        push3(7); @(negedge clk); @(negedge clk);
        push3(8'hFE); @(negedge clk); @(negedge clk);
        push3(5);
        begin
            int c = 0, en = 0;
            while (!ov3 && c < 20) begin en += int'(te3); c++; @(negedge clk); end
            chk("n3_lat", c, 3);
            chk("n3_ena", en, 2);
            chk("n3_sum", os3, 10);
        end
        @(negedge clk);

`ifdef ADDER_TREE_DRV_SHORT_FRAME_EN
        push4(9, 0); push4(6, 1);
        wait_out4("short", 15);
`else
        push4(9, 0); push4(6, 1); push4(1, 0); push4(1, 0);
        wait_out4("full", 17);
`endif
        @(negedge clk);
        chk("final_idle", {ov4, r4}, 2'b01);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
